// File: rtl/dcache_dm_wt_if.sv
// rtl/dcache_dm_wt_if.sv - CPU load/store port and line-granular memory port of the data cache
interface dcache_dm_wt_if #(
  parameter int ADDR_W = 32,
  parameter int LINE_W = 128
);
  // CPU side
  logic [ADDR_W-1:0]   cpu_addr;
  logic                cpu_read;
  logic                cpu_write;
  logic [31:0]         cpu_wdata;
  logic [3:0]          cpu_be;
  logic                cpu_flush;
  logic [31:0]         cpu_rdata;
  logic                cpu_stall;
  // Memory side
  logic [ADDR_W-5:0]   mem_addr;
  logic                mem_read;
  logic                mem_write;
  logic [LINE_W-1:0]   mem_wdata;
  logic [LINE_W/8-1:0] mem_be;
  logic [LINE_W-1:0]   mem_rdata;
  logic                mem_ack;

  // Cache view
  modport slave (
    input  cpu_addr, cpu_read, cpu_write, cpu_wdata, cpu_be, cpu_flush,
    input  mem_rdata, mem_ack,
    output cpu_rdata, cpu_stall,
    output mem_addr, mem_read, mem_write, mem_wdata, mem_be
  );

  // Core / memory-controller view
  modport master (
    output cpu_addr, cpu_read, cpu_write, cpu_wdata, cpu_be, cpu_flush,
    output mem_rdata, mem_ack,
    input  cpu_rdata, cpu_stall,
    input  mem_addr, mem_read, mem_write, mem_wdata, mem_be
  );
endinterface

// File: rtl/dcache_dm_wt.sv
// rtl/dcache_dm_wt.sv - direct-mapped write-through no-write-allocate data cache
module dcache_dm_wt #(
  parameter int NUM_LINES = 16,
  parameter int ADDR_W    = 32,
  parameter int LINE_W    = 128
) (
  input  logic           iCLK,
  input  logic           iRST_n,
  dcache_dm_wt_if.slave  bus
);

  localparam int INDEX_W = $clog2(NUM_LINES);
  localparam int TAG_W   = ADDR_W - INDEX_W - 4;
  localparam int LADDR_W = ADDR_W - 4;
  localparam int BE_W    = LINE_W / 8;

  typedef enum logic [1:0] {S_IDLE, S_READ, S_RESP, S_WRITE} state_t;

  state_t               state_q, state_d;
  logic [NUM_LINES-1:0] valid_q, valid_d;
  logic [TAG_W-1:0]     tag_q  [NUM_LINES];
  logic [TAG_W-1:0]     tag_d  [NUM_LINES];
  logic [LINE_W-1:0]    data_q [NUM_LINES];
  logic [LINE_W-1:0]    data_d [NUM_LINES];

  logic [LADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic                 mem_read_q, mem_read_d;
  logic                 mem_write_q, mem_write_d;
  logic [LINE_W-1:0]    mem_wdata_q, mem_wdata_d;
  logic [BE_W-1:0]      mem_be_q, mem_be_d;
  logic [31:0]          cpu_rdata_q, cpu_rdata_d;
  logic [1:0]           word_q, word_d;
  logic                 wr_hit_q, wr_hit_d;

  logic [INDEX_W-1:0]   cpu_index;
  logic [TAG_W-1:0]     cpu_tag;
  logic [1:0]           cpu_word;
  logic                 hit;
  logic [31:0]          hit_word;
  logic [INDEX_W-1:0]   line_index;
  logic [TAG_W-1:0]     line_tag;
  logic                 unused_addr_bits;

  assign cpu_index = bus.cpu_addr[INDEX_W+3:4];
  assign cpu_tag   = bus.cpu_addr[ADDR_W-1:INDEX_W+4];
  assign cpu_word  = bus.cpu_addr[3:2];
  assign hit       = valid_q[cpu_index] && (tag_q[cpu_index] == cpu_tag);
  assign hit_word  = data_q[cpu_index][32*cpu_word +: 32];

  // The latched line address locates the line that a refill or write-merge targets
  assign line_index = mem_addr_q[INDEX_W-1:0];
  assign line_tag   = mem_addr_q[LADDR_W-1:INDEX_W];

  // Byte offset within a word is meaningless for a word-wide port
  assign unused_addr_bits = ^bus.cpu_addr[1:0];

  // Next-state, refill, write-merge and flush decisions
  always_comb begin
    state_d     = state_q;
    valid_d     = valid_q;
    tag_d       = tag_q;
    data_d      = data_q;
    mem_addr_d  = mem_addr_q;
    mem_read_d  = mem_read_q;
    mem_write_d = mem_write_q;
    mem_wdata_d = mem_wdata_q;
    mem_be_d    = mem_be_q;
    cpu_rdata_d = cpu_rdata_q;
    word_d      = word_q;
    wr_hit_d    = wr_hit_q;

    unique case (state_q)
      S_IDLE: begin
        if (bus.cpu_write) begin
          // Stores always go through; remember whether the line is resident so the ack can merge
          mem_addr_d  = bus.cpu_addr[ADDR_W-1:4];
          mem_wdata_d = {(LINE_W/32){bus.cpu_wdata}};
          mem_be_d    = '0;
          mem_be_d[4*cpu_word +: 4] = bus.cpu_be;
          mem_write_d = 1'b1;
          word_d      = cpu_word;
          wr_hit_d    = hit;
          state_d     = S_WRITE;
        end else if (bus.cpu_read && !hit) begin
          mem_addr_d = bus.cpu_addr[ADDR_W-1:4];
          mem_read_d = 1'b1;
          word_d     = cpu_word;
          state_d    = S_READ;
        end else if (!bus.cpu_read && bus.cpu_flush) begin
          valid_d = '0;
        end
      end

      S_READ: begin
        if (bus.mem_ack) begin
          data_d[line_index]  = bus.mem_rdata;
          tag_d[line_index]   = line_tag;
          valid_d[line_index] = 1'b1;
          cpu_rdata_d         = bus.mem_rdata[32*word_q +: 32];
          mem_read_d          = 1'b0;
          state_d             = S_RESP;
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      S_WRITE: begin
        if (bus.mem_ack) begin
          mem_write_d = 1'b0;
          if (wr_hit_q) begin
            for (int b = 0; b < BE_W; b++) begin
              if (mem_be_q[b]) begin
                data_d[line_index][8*b +: 8] = mem_wdata_q[8*b +: 8];
              end
            end
          end
          state_d = S_IDLE;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  // Control, request and valid state; reset abandons any transaction in flight
  always_ff @(posedge iCLK or negedge iRST_n) begin
    if (!iRST_n) begin
      state_q     <= S_IDLE;
      valid_q     <= '0;
      mem_addr_q  <= '0;
      mem_read_q  <= 1'b0;
      mem_write_q <= 1'b0;
      mem_wdata_q <= '0;
      mem_be_q    <= '0;
      cpu_rdata_q <= '0;
      word_q      <= '0;
      wr_hit_q    <= 1'b0;
    end else begin
      state_q     <= state_d;
      valid_q     <= valid_d;
      mem_addr_q  <= mem_addr_d;
      mem_read_q  <= mem_read_d;
      mem_write_q <= mem_write_d;
      mem_wdata_q <= mem_wdata_d;
      mem_be_q    <= mem_be_d;
      cpu_rdata_q <= cpu_rdata_d;
      word_q      <= word_d;
      wr_hit_q    <= wr_hit_d;
    end
  end

  // Tag and data storage needs no reset: the valid bits gate every use
  always_ff @(posedge iCLK) begin
    tag_q  <= tag_d;
    data_q <= data_d;
  end

  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_read  = mem_read_q;
  assign bus.mem_write = mem_write_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.mem_be    = mem_be_q;

  assign bus.cpu_rdata = (state_q == S_IDLE && hit) ? hit_word : cpu_rdata_q;
  assign bus.cpu_stall = (bus.cpu_read || bus.cpu_write)
                       && !(state_q == S_IDLE && bus.cpu_read && hit && !bus.cpu_write)
                       && !(state_q == S_RESP)
                       && !(state_q == S_WRITE && bus.mem_ack);

endmodule

// File: tb/tb_dcache_dm_wt.sv
// tb/tb_dcache_dm_wt.sv - directed vector bench for dcache_dm_wt
module tb_dcache_dm_wt;

  logic iCLK = 1'b0;
  logic iRST_n = 1'b0;
  always #5 iCLK = ~iCLK;

  dcache_dm_wt_if bus ();

  dcache_dm_wt dut (
    .iCLK   (iCLK),
    .iRST_n (iRST_n),
    .bus    (bus)
  );

  typedef struct {
    logic         rd, wr, fl;
    logic [31:0]  addr, wd;
    logic [3:0]   be;
    logic         ack;
    logic [127:0] mrd;
    logic         e_stall, e_mrd, e_mwr, rchk;
    logic [31:0]  e_rdata;
    logic [27:0]  e_maddr;
    logic [15:0]  e_mbe;
  } vec_t;

  localparam logic [127:0] L1 = 128'h44444444_33333333_22222222_11111111;
  localparam logic [127:0] M2 = 128'hAAAA0003_AAAA0002_AAAA0001_AAAA0000;
  localparam logic [127:0] M3 = 128'hB3B3B3B3_B2B2B2B2_B1B1B1B1_B0B0B0B0;
  localparam logic [127:0] M4 = 128'hC3C3C3C3_C2C2C2C2_C1C1C1C1_C0C0C0C0;

  vec_t vecs[$];
  int   applied = 0;
  int   miscompares = 0;

  function automatic vec_t mk(input logic rd, input logic wr, input logic fl,
                              input logic [31:0] addr, input logic [31:0] wd,
                              input logic [3:0] be, input logic ack, input logic [127:0] mrd,
                              input logic e_stall, input logic e_mrd, input logic e_mwr,
                              input logic rchk, input logic [31:0] e_rdata,
                              input logic [27:0] e_maddr, input logic [15:0] e_mbe);
    vec_t v;
    v.rd = rd; v.wr = wr; v.fl = fl; v.addr = addr; v.wd = wd; v.be = be;
    v.ack = ack; v.mrd = mrd; v.e_stall = e_stall; v.e_mrd = e_mrd; v.e_mwr = e_mwr;
    v.rchk = rchk; v.e_rdata = e_rdata; v.e_maddr = e_maddr; v.e_mbe = e_mbe;
    return v;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    if (act !== exp) begin
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
      miscompares++;
    end
  endtask

  task automatic drive(input vec_t v);
    bus.cpu_read  = v.rd;
    bus.cpu_write = v.wr;
    bus.cpu_flush = v.fl;
    bus.cpu_addr  = v.addr;
    bus.cpu_wdata = v.wd;
    bus.cpu_be    = v.be;
    bus.mem_ack   = v.ack;
    bus.mem_rdata = v.mrd;
  endtask

  // Drive at the falling edge, compare 2ns later, then advance one cycle
  task automatic apply(input vec_t v, input string tag);
    drive(v);
    #2;
    applied++;
    chk({tag, " cpu_stall"}, 128'(bus.cpu_stall), 128'(v.e_stall));
    chk({tag, " mem_read"},  128'(bus.mem_read),  128'(v.e_mrd));
    chk({tag, " mem_write"}, 128'(bus.mem_write), 128'(v.e_mwr));
    if (v.e_mrd || v.e_mwr) chk({tag, " mem_addr"}, 128'(bus.mem_addr), 128'(v.e_maddr));
    if (v.e_mwr) begin
      chk({tag, " mem_be"},    128'(bus.mem_be), 128'(v.e_mbe));
      chk({tag, " mem_wdata"}, bus.mem_wdata, {4{v.wd}});
    end
    if (v.rchk) chk({tag, " cpu_rdata"}, 128'(bus.cpu_rdata), 128'(v.e_rdata));
    @(negedge iCLK);
  endtask

  initial begin
    vec_t idle;
    idle = mk(0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0);
    drive(idle);
    iRST_n = 1'b0;
    repeat (2) @(negedge iCLK);
    #2;
    applied++;
    chk("rst mem_read",  128'(bus.mem_read),  128'(0));
    chk("rst mem_write", 128'(bus.mem_write), 128'(0));
    chk("rst mem_addr",  128'(bus.mem_addr),  128'(0));
    chk("rst mem_wdata", bus.mem_wdata,       128'(0));
    chk("rst mem_be",    128'(bus.mem_be),    128'(0));
    chk("rst cpu_rdata", 128'(bus.cpu_rdata), 128'(0));
    chk("rst cpu_stall", 128'(bus.cpu_stall), 128'(0));
    @(negedge iCLK);
    iRST_n = 1'b1;

    // idle after reset
    vecs.push_back(mk(0,0,0,32'h0,0,0,0,0,          0,0,0,1,32'h0,0,0));
    // read miss 0x1008, refill, response, then zero-latency hit
    vecs.push_back(mk(1,0,0,32'h1008,0,0,0,0,       1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,32'h1008,0,0,0,0,       1,1,0,0,0,28'h100,0));
    vecs.push_back(mk(1,0,0,32'h1008,0,0,1,L1,      1,1,0,0,0,28'h100,0));
    vecs.push_back(mk(1,0,0,32'h1008,0,0,0,0,       0,0,0,1,32'h33333333,0,0));
    vecs.push_back(mk(1,0,0,32'h1008,0,0,0,0,       0,0,0,1,32'h33333333,0,0));
    // store hit 0x1004, mem_write held five cycles until ack
    vecs.push_back(mk(0,1,0,32'h1004,32'hDEADBEEF,4'h3,0,0, 1,0,0,0,0,0,0));
    for (int i = 0; i < 4; i++)
      vecs.push_back(mk(0,1,0,32'h1004,32'hDEADBEEF,4'h3,0,0, 1,0,1,0,0,28'h100,16'h0030));
    vecs.push_back(mk(0,1,0,32'h1004,32'hDEADBEEF,4'h3,1,0, 0,0,1,0,0,28'h100,16'h0030));
    vecs.push_back(mk(1,0,0,32'h1004,0,0,0,0,       0,0,0,1,32'h2222BEEF,0,0));
    // store miss 0x2000 does not allocate
    vecs.push_back(mk(0,1,0,32'h2000,32'h12345678,4'hF,0,0, 1,0,0,0,0,0,0));
    vecs.push_back(mk(0,1,0,32'h2000,32'h12345678,4'hF,1,0, 0,0,1,0,0,28'h200,16'h000F));
    vecs.push_back(mk(1,0,0,32'h2000,0,0,0,0,       1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,32'h2000,0,0,1,M2,      1,1,0,0,0,28'h200,0));
    vecs.push_back(mk(1,0,0,32'h2000,0,0,0,0,       0,0,0,1,32'hAAAA0000,0,0));
    // conflict at index 1: 0x0010 vs 0x0110
    vecs.push_back(mk(1,0,0,32'h0010,0,0,0,0,       1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,32'h0010,0,0,1,M3,      1,1,0,0,0,28'h001,0));
    vecs.push_back(mk(1,0,0,32'h0010,0,0,0,0,       0,0,0,1,32'hB0B0B0B0,0,0));
    vecs.push_back(mk(1,0,0,32'h0010,0,0,0,0,       0,0,0,1,32'hB0B0B0B0,0,0));
    vecs.push_back(mk(1,0,0,32'h0110,0,0,0,0,       1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,32'h0110,0,0,1,M4,      1,1,0,0,0,28'h011,0));
    vecs.push_back(mk(1,0,0,32'h0110,0,0,0,0,       0,0,0,1,32'hC0C0C0C0,0,0));
    vecs.push_back(mk(1,0,0,32'h0010,0,0,0,0,       1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,32'h0010,0,0,1,M3,      1,1,0,0,0,28'h001,0));
    vecs.push_back(mk(1,0,0,32'h0010,0,0,0,0,       0,0,0,1,32'hB0B0B0B0,0,0));
    // flush, then both previously cached lines miss
    vecs.push_back(mk(0,0,1,32'h0,0,0,0,0,          0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,32'h0010,0,0,0,0,       1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,32'h0010,0,0,1,M3,      1,1,0,0,0,28'h001,0));
    vecs.push_back(mk(1,0,0,32'h0010,0,0,0,0,       0,0,0,1,32'hB0B0B0B0,0,0));
    vecs.push_back(mk(1,0,0,32'h2000,0,0,0,0,       1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,32'h2000,0,0,1,M2,      1,1,0,0,0,28'h200,0));
    vecs.push_back(mk(1,0,0,32'h2000,0,0,0,0,       0,0,0,1,32'hAAAA0000,0,0));
    // write wins over simultaneous read; merged byte visible on next hit
    vecs.push_back(mk(1,1,0,32'h0010,32'h55,4'h1,0,0, 1,0,0,0,0,0,0));
    vecs.push_back(mk(1,1,0,32'h0010,32'h55,4'h1,1,0, 0,0,1,0,0,28'h001,16'h0001));
    vecs.push_back(mk(1,0,0,32'h0010,0,0,0,0,       0,0,0,1,32'hB0B0B055,0,0));
    // stray ack in IDLE is ignored
    vecs.push_back(mk(0,0,0,32'h0,0,0,1,0,          0,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,32'h0010,0,0,0,0,       0,0,0,1,32'hB0B0B055,0,0));
    // start a miss to 0x3000 that reset will abandon
    vecs.push_back(mk(1,0,0,32'h3000,0,0,0,0,       1,0,0,0,0,0,0));
    vecs.push_back(mk(1,0,0,32'h3000,0,0,0,0,       1,1,0,0,0,28'h300,0));

    foreach (vecs[i]) apply(vecs[i], $sformatf("v%0d", i));

    // Still in READ; asynchronous reset mid-cycle must drop mem_read at once
    drive(mk(1,0,0,32'h3000,0,0,0,0, 0,0,0,0,0,0,0));
    #2;
    iRST_n = 1'b0;
    #1;
    applied++;
    chk("midrst mem_read",  128'(bus.mem_read),  128'(0));
    chk("midrst mem_write", 128'(bus.mem_write), 128'(0));
    chk("midrst cpu_stall", 128'(bus.cpu_stall), 128'(1));
    @(negedge iCLK);
    iRST_n = 1'b1;
    // late ack after reset, no request pending
    apply(mk(0,0,0,32'h0,0,0,1,M2, 0,0,0,0,0,0,0), "late_ack");
    // 0x0010 was valid before reset, so it must miss now
    apply(mk(1,0,0,32'h0010,0,0,0,0,  1,0,0,0,0,0,0),           "post_rst miss");
    apply(mk(1,0,0,32'h0010,0,0,1,M3, 1,1,0,0,0,28'h001,0),     "post_rst refill");
    apply(mk(1,0,0,32'h0010,0,0,0,0,  0,0,0,1,32'hB0B0B0B0,0,0), "post_rst resp");
    drive(idle);

    $display("== %0d vectors applied, %0d miscompares ==", applied, miscompares);
    $finish;
  end

endmodule

// File: doc/dcache_dm_wt.md
Name: dcache_dm_wt

Overview:
- Direct-mapped, write-through, no-write-allocate data cache between the RV32I core's load/store port and the DDR memory interface.
- Converts word/byte CPU accesses into 128-bit line reads and masked 128-bit line writes.
- Downstream side uses a request/ack handshake and line-granular addresses; memory interface uses them as Avalon addresses.

Parameters:
- NUM_LINES, 16, number of cache lines (power of 2, ≥2); INDEX_W = log2(NUM_LINES)
- ADDR_W, 32, CPU byte address width
- LINE_W, 128, line width in bits (fixed 4 words)

Ports:
- iCLK  in  1  clock
- iRST_n  in  1  reset; asynchronous, active-low
- cpu_addr  in  32  byte address; [1:0] ignored, [3:2] word select
- cpu_read  in  1  load request, held until cpu_stall low
- cpu_write  in  1  store request, held until cpu_stall low
- cpu_wdata  in  32  store data
- cpu_be  in  4  store byte enables
- cpu_flush  in  1  invalidate all lines (honoured only in IDLE with no request)
- cpu_rdata  out  32  load data, valid when cpu_read && !cpu_stall
- cpu_stall  out  1  access not complete this cycle
- mem_addr  out  28  line address = cpu_addr[31:4]
- mem_read  out  1  line read request, held until mem_ack
- mem_write  out  1  line write request, held until mem_ack
- mem_wdata  out  128  store word replicated into all four lanes
- mem_be  out  16  byte mask; only the addressed word's cpu_be bits set
- mem_rdata  in  128  refill data, sampled on mem_ack during READ
- mem_ack  in  1  one-cycle completion pulse

Behaviour:
- Address split: offset [3:0], index [INDEX_W+3:4], tag [31:INDEX_W+4]. Per line: valid bit, tag, 128-bit data, all flops.
- Reset (async): state=IDLE; all valid=0; mem_read=mem_write=0; mem_addr=0, mem_wdata=0, mem_be=0; cpu_rdata=0. Reset mid-transaction abandons it; requests drop the same edge.
- hit = valid[index] && tag match (combinational on cpu_addr).
- States: IDLE, READ, RESP, WRITE.
- IDLE:
  - cpu_write (priority over cpu_read if both high): latch addr/data/be into mem_* regs, mem_write=1, go WRITE.
  - Else cpu_read && hit: cpu_rdata = selected word combinationally, cpu_stall=0, stay IDLE. Zero-latency hit.
  - Else cpu_read && miss: mem_addr latched, mem_read=1, go READ.
  - Else cpu_flush: clear all valid bits next edge.
- cpu_stall = (cpu_read||cpu_write) && !(IDLE && read hit && !cpu_write) && !(state==RESP) && !(WRITE && mem_ack).
- READ: hold mem_read/mem_addr. On mem_ack: store mem_rdata into line, set tag and valid, capture the word into cpu_rdata register, mem_read=0, go RESP.
- RESP: cpu_rdata from capture register, cpu_stall=0, go IDLE. Read miss latency = ack cycle + 1.
- WRITE: hold mem_write/mem_wdata/mem_be. On mem_ack: mem_write=0, cpu_stall=0 this cycle, go IDLE.
  - If the latched address hit at issue, merge the enabled bytes into the cached line on the ack edge.
  - A miss does not allocate.
- mem_read and mem_write are never both high. Neither rises without a pending CPU request.
- mem_ack outside READ/WRITE is ignored.
- cpu_addr change while stalled is a protocol violation; the latched address is used.
- Index wrap: equal-index different-tag addresses evict each other; no associativity.

Test Plan:
- Reset, then load 0x0000_1008 (miss): mem_read=1, mem_addr=0x0000100. Ack with mem_rdata=0x44444444_33333333_22222222_11111111 → next cycle cpu_rdata=0x33333333, stall low. Re-read 0x1008 → same-cycle 0x33333333, no mem_read.
- Store 0xDEADBEEF, be=4'b0011 to 0x0000_1004 (hit): mem_write=1, mem_be=16'h0030, held 5 cycles until ack. Then load 0x1004 hits → 0x2222BEEF.
- Store to uncached 0x0000_2000: mem_write issued. Following load of 0x2000 misses (no allocate) → mem_read.
- Conflict: fill 0x0000_0010, then load 0x0000_0110 (NUM_LINES=16, same index). Refill evicts; reload of 0x0010 misses again.
- cpu_flush in IDLE after fills: next load of any previously cached address issues mem_read.
- Assert iRST_n=0 while in READ before ack: mem_read drops immediately, valid cleared. A late mem_ack after reset is ignored, and the next load misses.
